// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Arbitrates the core's instruction-fetch and data ports onto
//               one shared bus. A pending data access wins over a pending
//               fetch. Each returned word is held in a capture register, and
//               a stall is raised while any request is still outstanding.
// Options     : ARB_TIMEOUT_EN - when defined, an access with no ack for
//               TIMEOUT cycles ends with data 0 and a one-cycle bus_err_o
//               pulse. When undefined, the arbiter waits for ack forever.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_ce_i,
    input  logic [31:0] rom_addr_i,
    output logic [31:0] rom_data_o,
    input  logic        ram_ce_i,
    input  logic        ram_we_i,
    input  logic [3:0]  ram_sel_i,
    input  logic [31:0] ram_addr_i,
    input  logic [31:0] ram_data_i,
    output logic [31:0] ram_data_o,
    output logic        stallreq_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_DATA = 2'd1;
    localparam logic [1:0] c_INST = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic        r_dvalid;
    logic        r_ivalid;
    logic [31:0] r_rom_data;
    logic [31:0] r_ram_data;
    logic        w_stall;
    logic        w_timeout;
    logic        w_done;

    // A valid flag set means that request has been served for this pipeline step
    assign w_stall = (ram_ce_i & ~r_dvalid) | (rom_ce_i & ~r_ivalid);
    // A bus access ends on ack, or on timeout when timeout support is built in
    assign w_done  = (r_state != c_IDLE) && (bus_ack_i || w_timeout);

`ifdef ARB_TIMEOUT_EN
    localparam int                 c_CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;

    // Count the cycles spent waiting for ack. The count restarts from zero on every access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == c_IDLE || bus_ack_i || w_timeout) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state != c_IDLE) && !bus_ack_i && (r_cnt == c_LIMIT);

    // Error pulse lasts one cycle and lines up with the return to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
        end
    end

    assign bus_err_o = r_err;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign bus_err_o        = 1'b0;
    assign w_unused_timeout = ^TIMEOUT;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: a data access wins over a fetch; a busy state holds until the access ends
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (ram_ce_i && !r_dvalid) begin
                    w_next = c_DATA;
                end else if (rom_ce_i && !r_ivalid) begin
                    w_next = c_INST;
                end
            end
            c_DATA, c_INST: begin
                if (w_done) begin
                    w_next = c_IDLE;
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    // Bus outputs are decoded from the state alone. They are zero in IDLE.
    always_comb begin
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_sel_o   = 4'b0000;
        bus_addr_o  = 32'h0;
        bus_wdata_o = 32'h0;
        case (r_state)
            c_DATA: begin
                bus_req_o   = 1'b1;
                bus_we_o    = ram_we_i;
                bus_sel_o   = ram_sel_i;
                bus_addr_o  = ram_addr_i;
                bus_wdata_o = ram_data_i;
            end
            c_INST: begin
                bus_req_o   = 1'b1;
                bus_sel_o   = 4'b1111;
                bus_addr_o  = rom_addr_i;
            end
            default: ;
        endcase
    end

    // Capture returned words and track per-port completion. A capture takes priority over the advance-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvalid   <= 1'b0;
            r_ivalid   <= 1'b0;
            r_rom_data <= 32'h0;
            r_ram_data <= 32'h0;
        end else begin
            if (!w_stall) begin
                r_dvalid <= 1'b0;
                r_ivalid <= 1'b0;
            end
            if (r_state == c_DATA && w_done) begin
                r_dvalid <= 1'b1;
                if (w_timeout) begin
                    r_ram_data <= 32'h0;
                end else if (!ram_we_i) begin
                    r_ram_data <= bus_rdata_i;
                end
            end
            if (r_state == c_INST && w_done) begin
                r_ivalid   <= 1'b1;
                r_rom_data <= w_timeout ? 32'h0 : bus_rdata_i;
            end
        end
    end

    assign stallreq_o = w_stall;
    assign rom_data_o = r_rom_data;
    assign ram_data_o = r_ram_data;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Directed, self-checking bench for bus_arbiter. Expected
//               values are computed by hand and checked one cycle at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;
    logic        ram_ce_i;
    logic        ram_we_i;
    logic [3:0]  ram_sel_i;
    logic [31:0] ram_addr_i;
    logic [31:0] ram_data_i;
    logic [31:0] ram_data_o;
    logic        stallreq_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        bus_err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o),
        .ram_ce_i(ram_ce_i), .ram_we_i(ram_we_i), .ram_sel_i(ram_sel_i),
        .ram_addr_i(ram_addr_i), .ram_data_i(ram_data_i), .ram_data_o(ram_data_o),
        .stallreq_o(stallreq_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
    );

    // Advance one clock; outputs are then sampled and inputs driven 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rom_ce_i = 0; rom_addr_i = 0; ram_ce_i = 0; ram_we_i = 0;
        ram_sel_i = 0; ram_addr_i = 0; ram_data_i = 0; bus_rdata_i = 0; bus_ack_i = 0;
        step(); step();
        checks++; if (bus_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus_req_o); end
        checks++; if (rom_data_o !== 32'h0) begin errors++; $display("FAIL reset_rom got %h exp 0", rom_data_o); end
        checks++; if (ram_data_o !== 32'h0) begin errors++; $display("FAIL reset_ram got %h exp 0", ram_data_o); end
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stallreq_o); end
        checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus_err_o); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fetch();
        rom_ce_i = 1; rom_addr_i = 32'h100;
        #1;
        checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL fetch_stall0 got %b exp 1", stallreq_o); end
        checks++; if (bus_req_o !== 1'b0) begin errors++; $display("FAIL fetch_idle_req got %b exp 0", bus_req_o); end
        step();
        checks++; if ({bus_req_o, bus_we_o, bus_sel_o} !== 6'b10_1111) begin errors++; $display("FAIL fetch_ctl got %b exp 101111", {bus_req_o, bus_we_o, bus_sel_o}); end
        checks++; if (bus_addr_o !== 32'h100) begin errors++; $display("FAIL fetch_addr got %h exp 00000100", bus_addr_o); end
        checks++; if (bus_wdata_o !== 32'h0) begin errors++; $display("FAIL fetch_wdata got %h exp 0", bus_wdata_o); end
        bus_ack_i = 1; bus_rdata_i = 32'h3C010001;
        step();
        checks++; if (rom_data_o !== 32'h3C010001) begin errors++; $display("FAIL fetch_data got %h exp 3c010001", rom_data_o); end
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL fetch_stall2 got %b exp 0", stallreq_o); end
        checks++; if (bus_req_o !== 1'b0) begin errors++; $display("FAIL fetch_req_done got %b exp 0", bus_req_o); end
        bus_ack_i = 0; rom_ce_i = 0;
        step();
    endtask

    task automatic test_simultaneous();
        ram_ce_i = 1; ram_we_i = 0; ram_sel_i = 4'hF; ram_addr_i = 32'h2000;
        rom_ce_i = 1; rom_addr_i = 32'h104;
        step();
        checks++; if (bus_addr_o !== 32'h2000 || bus_req_o !== 1'b1) begin errors++; $display("FAIL sim_data_addr got %h/%b exp 00002000/1", bus_addr_o, bus_req_o); end
        bus_ack_i = 1; bus_rdata_i = 32'h11223344;
        step();
        checks++; if (ram_data_o !== 32'h11223344) begin errors++; $display("FAIL sim_ram_data got %h exp 11223344", ram_data_o); end
        checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL sim_stall_mid got %b exp 1", stallreq_o); end
        checks++; if (bus_req_o !== 1'b0) begin errors++; $display("FAIL sim_idle_req got %b exp 0", bus_req_o); end
        bus_ack_i = 0;
        step();
        checks++; if (bus_addr_o !== 32'h104 || bus_sel_o !== 4'hF) begin errors++; $display("FAIL sim_inst_addr got %h/%h exp 00000104/f", bus_addr_o, bus_sel_o); end
        bus_ack_i = 1; bus_rdata_i = 32'h55667788;
        step();
        checks++; if (rom_data_o !== 32'h55667788) begin errors++; $display("FAIL sim_rom_data got %h exp 55667788", rom_data_o); end
        checks++; if (ram_data_o !== 32'h11223344) begin errors++; $display("FAIL sim_ram_hold got %h exp 11223344", ram_data_o); end
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL sim_stall_end got %b exp 0", stallreq_o); end
        bus_ack_i = 0; ram_ce_i = 0; rom_ce_i = 0;
        step();
    endtask

    task automatic test_write_delay();
        ram_ce_i = 1; ram_we_i = 1; ram_sel_i = 4'b0011; ram_addr_i = 32'h3000; ram_data_i = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bus_req_o, bus_we_o, bus_sel_o} !== 6'b11_0011 || bus_addr_o !== 32'h3000 || bus_wdata_o !== 32'hDEADBEEF || stallreq_o !== 1'b1) begin
                errors++;
                $display("FAIL wr_hold%0d got ctl %b addr %h wdata %h stall %b exp 110011 00003000 deadbeef 1", i, {bus_req_o, bus_we_o, bus_sel_o}, bus_addr_o, bus_wdata_o, stallreq_o);
            end
        end
        bus_ack_i = 1; bus_rdata_i = 32'hFFFFFFFF;
        step();
        checks++; if (ram_data_o !== 32'h11223344) begin errors++; $display("FAIL wr_ram_keep got %h exp 11223344", ram_data_o); end
        checks++; if (stallreq_o !== 1'b0 || bus_req_o !== 1'b0) begin errors++; $display("FAIL wr_done got stall %b req %b exp 0 0", stallreq_o, bus_req_o); end
        bus_ack_i = 0; ram_ce_i = 0; ram_we_i = 0;
        step();
    endtask

    task automatic test_ack_in_idle();
        bus_ack_i = 1; bus_rdata_i = 32'hAAAA5555;
        step();
        checks++; if (ram_data_o !== 32'h11223344 || rom_data_o !== 32'h55667788) begin errors++; $display("FAIL idle_ack got %h/%h exp 11223344/55667788", ram_data_o, rom_data_o); end
        checks++; if (bus_req_o !== 1'b0) begin errors++; $display("FAIL idle_ack_req got %b exp 0", bus_req_o); end
        bus_ack_i = 0;
        step();
    endtask

    task automatic test_reset_mid_access();
        ram_ce_i = 1; ram_we_i = 0; ram_sel_i = 4'hF; ram_addr_i = 32'h4000;
        step();
        checks++; if (bus_req_o !== 1'b1) begin errors++; $display("FAIL rm_req1 got %b exp 1", bus_req_o); end
        step();
        checks++; if (bus_req_o !== 1'b1) begin errors++; $display("FAIL rm_req2 got %b exp 1", bus_req_o); end
        rst = 1;
        step();
        checks++; if (bus_req_o !== 1'b0 || bus_addr_o !== 32'h0 || bus_sel_o !== 4'h0) begin errors++; $display("FAIL rm_bus got req %b addr %h sel %h exp 0 0 0", bus_req_o, bus_addr_o, bus_sel_o); end
        checks++; if (ram_data_o !== 32'h0 || rom_data_o !== 32'h0) begin errors++; $display("FAIL rm_data got %h/%h exp 0/0", ram_data_o, rom_data_o); end
        rst = 0; ram_ce_i = 0; bus_ack_i = 1; bus_rdata_i = 32'h12345678;
        step();
        checks++; if (ram_data_o !== 32'h0 || bus_req_o !== 1'b0) begin errors++; $display("FAIL rm_late_ack got %h/%b exp 0/0", ram_data_o, bus_req_o); end
        bus_ack_i = 0;
        step();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        ram_ce_i = 1; ram_we_i = 0; ram_sel_i = 4'hF; ram_addr_i = 32'h5000;
        step();
        bus_ack_i = 1; bus_rdata_i = 32'h00000077;
        step();
        checks++; if (ram_data_o !== 32'h77) begin errors++; $display("FAIL to_pre got %h exp 00000077", ram_data_o); end
        bus_ack_i = 0; ram_ce_i = 0;
        step();
        ram_ce_i = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus_req_o !== 1'b1 || bus_err_o !== 1'b0) begin errors++; $display("FAIL to_wait%0d got req %b err %b exp 1 0", i, bus_req_o, bus_err_o); end
        end
        step();
        checks++; if (bus_err_o !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", bus_err_o); end
        checks++; if (ram_data_o !== 32'h0) begin errors++; $display("FAIL to_data got %h exp 0", ram_data_o); end
        checks++; if (stallreq_o !== 1'b0 || bus_req_o !== 1'b0) begin errors++; $display("FAIL to_stall got %b/%b exp 0/0", stallreq_o, bus_req_o); end
        ram_ce_i = 0;
        step();
        checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL to_err_once got %b exp 0", bus_err_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_write_delay();
        test_ack_in_idle();
        test_reset_mid_access();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the ack-wait limit in cycles (used only with ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port rom_ce_i  in  1  instruction fetch request from the core.
REQ-005 SHALL have port rom_addr_i  in  32  fetch address.
REQ-006 SHALL have port rom_data_o  out  32  captured instruction word.
REQ-007 SHALL have port ram_ce_i  in  1  data access request from the core.
REQ-008 SHALL have port ram_we_i  in  1  data write (1) / read (0).
REQ-009 SHALL have port ram_sel_i  in  4  data byte enables.
REQ-010 SHALL have port ram_addr_i  in  32  data address.
REQ-011 SHALL have port ram_data_i  in  32  data write value.
REQ-012 SHALL have port ram_data_o  out  32  captured read data.
REQ-013 SHALL have port stallreq_o  out  1  pipeline stall request to the core controller.
REQ-014 SHALL have port bus_req_o  out  1  shared-bus request.
REQ-015 SHALL have port bus_we_o  out  1  shared-bus write enable.
REQ-016 SHALL have port bus_sel_o  out  4  shared-bus byte enables.
REQ-017 SHALL have port bus_addr_o  out  32  shared-bus address.
REQ-018 SHALL have port bus_wdata_o  out  32  shared-bus write data.
REQ-019 SHALL have port bus_rdata_i  in  32  shared-bus read data, valid with ack.
REQ-020 SHALL have port bus_ack_i  in  1  shared-bus completion strobe.
REQ-021 SHALL have port bus_err_o  out  1  one-cycle timeout-error pulse.

Function
REQ-022 SHALL implement FSM states IDLE, DATA, INST.
REQ-023 SHALL, in IDLE, go to DATA next cycle if ram_ce_i is high and dvalid is low; otherwise go to INST if rom_ce_i is high and ivalid is low; otherwise stay in IDLE. Data wins over fetch when both are pending.
REQ-024 SHALL drive bus_req_o=1 combinationally only in DATA or INST; bus_req_o is 0 in IDLE.
REQ-025 SHALL, in DATA, drive bus_we_o/bus_sel_o/bus_addr_o/bus_wdata_o from ram_we_i/ram_sel_i/ram_addr_i/ram_data_i.
REQ-026 SHALL, in INST, drive bus_we_o=0, bus_sel_o=4'b1111, bus_addr_o=rom_addr_i, bus_wdata_o=0.
REQ-027 SHALL, in IDLE, drive all bus_* outputs to 0.
REQ-028 SHALL, in DATA on a bus_ack_i cycle, load bus_rdata_i into ram_data_o (reads only; writes leave ram_data_o unchanged), set dvalid, and return to IDLE; INST is identical with rom_data_o/ivalid.
REQ-029 SHALL hold the state and bus outputs stable while ack is absent.
REQ-030 SHALL ignore bus_ack_i in IDLE.
REQ-031 SHALL drive stallreq_o = (ram_ce_i & ~dvalid) | (rom_ce_i & ~ivalid), combinationally.
REQ-032 SHALL clear both dvalid and ivalid on any edge where stallreq_o is 0 (pipeline advances).
REQ-033 SHALL give a minimum latency of 2 cycles from request to stallreq_o low (request in IDLE, ack in the first DATA/INST cycle); data plus fetch together take a minimum of 4 cycles.
REQ-034 SHALL keep rom_data_o and ram_data_o stable until the next capture.

Reset
REQ-035 SHALL, on rst=1 at an edge, force state IDLE, dvalid=ivalid=0, rom_data_o=ram_data_o=0, bus_err_o=0, and the timeout counter to 0.
REQ-036 SHALL treat rst as overriding everything else, including mid-access: bus_req_o=0 from the first cycle after reset, and a late ack is ignored.

Configuration
REQ-037 SHALL, with ARB_TIMEOUT_EN defined, count cycles in DATA/INST without ack (counter resets on entering the state); when the count reaches TIMEOUT with no ack, capture 0 as data, set the matching valid flag, pulse bus_err_o for exactly one cycle, and return to IDLE.
REQ-038 SHALL, without ARB_TIMEOUT_EN, wait for ack indefinitely, with bus_err_o tied to 0 and no counter logic.

Verification
REQ-039 SHALL cover fetch-only: rom_ce_i=1, addr 0x100, ack on 1st INST cycle with data 0x3C010001 -> rom_data_o=0x3C010001, stallreq_o low at cycle 2.
REQ-040 SHALL cover simultaneous requests: ram read at 0x2000 plus fetch at 0x104 -> DATA served first (bus_addr_o=0x2000), then INST (0x104); stallreq_o low after both complete.
REQ-041 SHALL cover a write with 3-cycle ack delay: ram_we_i=1, sel=4'b0011, data 0xDEADBEEF -> bus outputs held stable for 3 cycles, ram_data_o unchanged.
REQ-042 SHALL cover reset mid-access: rst pulsed in the 2nd DATA cycle -> IDLE, bus_req_o=0, outputs 0; a following ack has no effect.
REQ-043 SHALL cover, with ARB_TIMEOUT_EN and TIMEOUT=4, no ack -> bus_err_o pulses once, ram_data_o=0, stallreq_o drops.
